bus_arbiter: RTL and testbench

//  Two-master arbiter for the serial bus. Grants bus ownership to m1 or m2 and

---
 rtl/bus_arbiter_if.sv | 40 ++++
 rtl/bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_bus_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the two bus masters and the arbiter.
// Masters drive requests and split events; the arbiter drives grants.
interface bus_arbiter_if;
   logic m1_req;
   logic m2_req;
   logic split;
   logic split_resume;
   logic m1_grant;
   logic m2_grant;
   logic m1_sel;
   logic m2_sel;
   logic bus_busy;
   logic timeout_err;

   modport master (
      output m1_req,
      output m2_req,
      output split,
      output split_resume,
      input  m1_grant,
      input  m2_grant,
      input  m1_sel,
      input  m2_sel,
      input  bus_busy,
      input  timeout_err
   );

   modport slave (
      input  m1_req,
      input  m2_req,
      input  split,
      input  split_resume,
      output m1_grant,
      output m2_grant,
      output m1_sel,
      output m2_sel,
      output bus_busy,
      output timeout_err
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master serial bus arbiter with split parking, resume and
// a watchdog that revokes a grant held for TIMEOUT cycles.
module bus_arbiter #(
   parameter bit          RR_EN   = 1'b0,
   parameter int unsigned TIMEOUT = 1023,
   parameter int unsigned CNT_W   = 10
) (
   input  logic          clk,
   input  logic          rstn,
   bus_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      M_NONE = 2'd0,
      M_1    = 2'd1,
      M_2    = 2'd2
   } mst_e;

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   state_e           state_q,  state_d;
   mst_e             parked_q, parked_d;
   mst_e             last_q,   last_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             pend_q,   pend_d;
   logic             g1_q,     g1_d;
   logic             g2_q,     g2_d;
   logic             busy_q,   busy_d;
   logic             terr_q,   terr_d;

   mst_e             win;
   mst_e             owner;
   logic             elig1;
   logic             elig2;
   logic             own_req;
   logic [CNT_W-1:0] cnt_inc;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         parked_q <= M_NONE;
         last_q   <= M_2;
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         g1_q     <= 1'b0;
         g2_q     <= 1'b0;
         busy_q   <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         parked_q <= parked_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         g1_q     <= g1_d;
         g2_q     <= g2_d;
         busy_q   <= busy_d;
         terr_q   <= terr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      parked_d = parked_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      g1_d     = g1_q;
      g2_d     = g2_q;
      busy_d   = busy_q;
      terr_d   = 1'b0;
      win      = M_NONE;
      owner    = g1_q ? M_1 : M_2;
      own_req  = g1_q ? bus.m1_req : bus.m2_req;
      elig1    = bus.m1_req && (parked_q != M_1);
      elig2    = bus.m2_req && (parked_q != M_2);
      cnt_inc  = (cnt_q == TMO) ? cnt_q : cnt_q + CNT_W'(1);

      if (bus.split_resume && (parked_q != M_NONE))
         pend_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            // A resumed master wins even if its request is low.
            if (pend_q && (parked_q != M_NONE)) begin
               win      = parked_q;
               pend_d   = 1'b0;
               parked_d = M_NONE;
            end else if (elig1 && elig2) begin
               if (RR_EN)
                  win = (last_q == M_1) ? M_2 : M_1;
               else
                  win = M_1;
            end else if (elig1) begin
               win = M_1;
            end else if (elig2) begin
               win = M_2;
            end

            if (win != M_NONE) begin
               state_d = GRANT;
               g1_d    = (win == M_1);
               g2_d    = (win == M_2);
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end

         GRANT: begin
            cnt_d  = cnt_inc;
            last_d = owner;
            if (bus.split) begin
               // Only one master may be parked; a second split just releases.
               if (parked_q == M_NONE)
                  parked_d = owner;
               state_d = RELEASE;
            end else if (!own_req) begin
               state_d = RELEASE;
            end else if (cnt_inc == TMO) begin
               terr_d  = 1'b1;
               state_d = RELEASE;
            end

            if (state_d == RELEASE) begin
               g1_d   = 1'b0;
               g2_d   = 1'b0;
               busy_d = 1'b0;
            end
         end

         RELEASE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            g1_d    = 1'b0;
            g2_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.m1_grant    = g1_q;
   assign bus.m2_grant    = g2_q;
   assign bus.m1_sel      = g1_q;
   assign bus.m2_sel      = g2_q;
   assign bus.bus_busy    = busy_q;
   assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: fixed-priority and round-robin
// instances run in lockstep with hand-derived per-cycle expectations.
module tb_bus_arbiter;

   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   bus_arbiter_if if0 ();
   bus_arbiter_if if1 ();

   bus_arbiter #(
      .RR_EN   (1'b0),
      .TIMEOUT (16),
      .CNT_W   (10)
   ) u_dut0 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if0)
   );

   bus_arbiter #(
      .RR_EN   (1'b1),
      .TIMEOUT (16),
      .CNT_W   (10)
   ) u_dut1 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if1)
   );

   typedef struct {
      string      tag;
      logic [5:0] e0;
      logic [5:0] e1;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // g: 0 = no owner, 1 = m1, 2 = m2; t = timeout_err
   function automatic logic [5:0] ev(int g, bit t);
      logic a;
      logic b;
      a = (g == 1);
      b = (g == 2);
      return {a, b, a, b, a | b, t};
   endfunction

   function automatic logic [5:0] obs0();
      return {if0.m1_grant, if0.m2_grant, if0.m1_sel,
              if0.m2_sel, if0.bus_busy, if0.timeout_err};
   endfunction

   function automatic logic [5:0] obs1();
      return {if1.m1_grant, if1.m2_grant, if1.m1_sel,
              if1.m2_sel, if1.bus_busy, if1.timeout_err};
   endfunction

   task automatic chk(string tag, logic [5:0] got, logic [5:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%b exp=%b (g1 g2 s1 s2 busy terr)",
                  tag, got, exp);
      end
   endtask

   task automatic drv(bit a, bit b, bit s, bit r);
      if0.m1_req       = a;
      if0.m2_req       = b;
      if0.split        = s;
      if0.split_resume = r;
      if1.m1_req       = a;
      if1.m2_req       = b;
      if1.split        = s;
      if1.split_resume = r;
   endtask

   task automatic cyc(string tag, bit a, bit b, bit s, bit r,
                      int g0, int g1, bit t);
      exp_t e;
      drv(a, b, s, r);
      sb.push_back('{tag, ev(g0, t), ev(g1, t)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, "/d0"}, obs0(), e.e0);
      chk({e.tag, "/d1"}, obs1(), e.e1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      drv(0, 0, 0, 0);
      #12;
      chk("rst/d0", obs0(), 6'b0);
      chk("rst/d1", obs1(), 6'b0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // single requester, release and turnaround
      cyc("t1a", 1, 0, 0, 0, 1, 1, 0);
      cyc("t1b", 1, 0, 0, 0, 1, 1, 0);
      cyc("t1c", 0, 0, 0, 0, 0, 0, 0);
      cyc("t1d", 0, 0, 0, 0, 0, 0, 0);
      cyc("t1e", 0, 0, 0, 0, 0, 0, 0);

      // simultaneous requests: d0 fixed m1, d1 round-robin (last=m1)
      cyc("t2a", 1, 1, 0, 0, 1, 2, 0);
      cyc("t2b", 1, 1, 0, 0, 1, 2, 0);
      cyc("t2c", 0, 1, 0, 0, 0, 2, 0);
      cyc("t2d", 0, 1, 0, 0, 0, 2, 0);
      cyc("t2e", 0, 1, 0, 0, 2, 2, 0);
      cyc("t2f", 0, 0, 0, 0, 0, 0, 0);
      cyc("t2g", 0, 0, 0, 0, 0, 0, 0);
      cyc("t2h", 0, 0, 0, 0, 0, 0, 0);

      // both held: watchdog ends each tenure; d1 alternates
      for (int t = 0; t < 4; t++) begin
         for (int j = 0; j < 18; j++) begin
            cyc($sformatf("t3_%0d_%0d", t, j), 1, 1, 0, 0,
                (j < 16) ? 1 : 0,
                (j < 16) ? ((t % 2 == 0) ? 1 : 2) : 0,
                j == 16);
         end
      end

      // m2 alone held: timeout then re-grant
      for (int t = 0; t < 2; t++) begin
         for (int j = 0; j < 18; j++) begin
            cyc($sformatf("t5_%0d_%0d", t, j), 0, 1, 0, 0,
                (j < 16) ? 2 : 0, (j < 16) ? 2 : 0, j == 16);
         end
      end
      cyc("t5z", 0, 0, 0, 0, 0, 0, 0);

      // split parks m1, m2 served, resume re-grants m1
      cyc("t4a", 1, 1, 0, 0, 1, 1, 0);
      cyc("t4b", 1, 1, 1, 0, 0, 0, 0);
      cyc("t4c", 1, 1, 0, 0, 0, 0, 0);
      cyc("t4d", 1, 1, 0, 0, 2, 2, 0);
      cyc("t4e", 1, 1, 0, 1, 2, 2, 0);
      cyc("t4f", 1, 0, 0, 0, 0, 0, 0);
      cyc("t4g", 0, 0, 0, 0, 0, 0, 0);
      cyc("t4h", 0, 0, 0, 0, 1, 1, 0);
      cyc("t4i", 0, 0, 0, 0, 0, 0, 0);
      cyc("t4j", 0, 0, 0, 0, 0, 0, 0);
      cyc("t4k", 0, 0, 0, 0, 0, 0, 0);

      // split outside GRANT has no effect
      cyc("t4l", 0, 0, 1, 0, 0, 0, 0);
      cyc("t4m", 1, 0, 0, 0, 1, 1, 0);
      cyc("t4n", 0, 0, 0, 0, 0, 0, 0);
      cyc("t4o", 0, 0, 0, 0, 0, 0, 0);

      // second split while m1 parked does not park m2
      cyc("s01", 1, 0, 0, 0, 1, 1, 0);
      cyc("s02", 1, 0, 1, 0, 0, 0, 0);
      cyc("s03", 1, 1, 0, 0, 0, 0, 0);
      cyc("s04", 1, 1, 0, 0, 2, 2, 0);
      cyc("s05", 1, 1, 1, 0, 0, 0, 0);
      cyc("s06", 1, 1, 0, 0, 0, 0, 0);
      cyc("s07", 1, 1, 0, 0, 2, 2, 0);
      cyc("s08", 1, 0, 0, 0, 0, 0, 0);
      cyc("s09", 1, 0, 0, 0, 0, 0, 0);
      cyc("s10", 1, 0, 0, 1, 0, 0, 0);
      cyc("s11", 1, 0, 0, 0, 1, 1, 0);
      cyc("s12", 0, 0, 0, 0, 0, 0, 0);
      cyc("s13", 0, 0, 0, 0, 0, 0, 0);

      // async reset with m2 granted and m1 parked
      cyc("t6a", 1, 0, 0, 0, 1, 1, 0);
      cyc("t6b", 1, 0, 1, 0, 0, 0, 0);
      cyc("t6c", 0, 1, 0, 0, 0, 0, 0);
      cyc("t6d", 0, 1, 0, 0, 2, 2, 0);
      rstn = 1'b0;
      #1;
      chk("t6rst/d0", obs0(), 6'b0);
      chk("t6rst/d1", obs1(), 6'b0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      cyc("t6e", 1, 0, 0, 0, 1, 1, 0);
      cyc("t6f", 0, 0, 0, 0, 0, 0, 0);
      cyc("t6g", 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
